alu_share_ctrl: RTL and testbench

Sequencer and arbiter that shares the single combinational ALU between two requesters (requester 0: core execute stage, requester 1: auxiliary/coprocessor port). It accepts one operation at a time over a valid/ready handshake, round-robin arbitrates simultaneous requests, and registers the operands driven into the ALU. It holds the ALU inputs stable for one cycle, or for `MUL_LAT` cycles on MUL, then captures the 64-bit result and flags and returns them to the granted requester over a valid/ready response handshake.

---
 rtl/alu_share_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Sequencer/arbiter that lets two requesters share one combinational ALU.
// Requester 0 is the core execute stage, requester 1 the auxiliary port.
// One operation is in flight at a time:
//   IDLE : combinational round-robin grant, request accepted on valid&ready
//   EXEC : registered operands held on alu_* for 1 cycle (MUL_LAT on MUL)
//   RESP : captured result/flags held on rsp_* until the owner takes them
//
// Opcode map seen by the ALU (only MUL matters to this block):
//   0 ADD, 1 SUB, 2 MUL, ... 12 SHL, 13 SHR. 14/15 are forwarded unchanged.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   rN_valid / rN_ready          request handshake (ready is combinational)
//   rN_opcode, rN_a, rN_b,
//   rN_imm, rN_src_sel, rN_shamt request fields, sampled on accept only
//   rN_rsp_valid / rN_rsp_ready  response handshake towards requester N
//   rsp_data, rsp_z, rsp_c       registered result and flags (shared)
//   busy                         high whenever the FSM is not in IDLE
//   alu_enable                   high while the ALU is executing
//   alu_opcode, alu_a, alu_b,
//   alu_imm, alu_shift_amt,
//   alu_src_sel                  registered operands towards the ALU
//   alu_data, alu_z, alu_c       combinational ALU result
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [3:0]  r0_opcode,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r0_imm,
    input  logic        r0_src_sel,
    input  logic [4:0]  r0_shamt,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [3:0]  r1_opcode,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [31:0] r1_imm,
    input  logic        r1_src_sel,
    input  logic [4:0]  r1_shamt,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,

    output logic [63:0] rsp_data,
    output logic        rsp_z,
    output logic        rsp_c,
    output logic        busy,

    output logic        alu_enable,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_shift_amt,
    output logic        alu_src_sel,
    input  logic [63:0] alu_data,
    input  logic        alu_z,
    input  logic        alu_c
);

    localparam logic [3:0] OP_MUL       = 4'd2;
    // cnt counts the extra EXEC cycles beyond the first one
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic        last_gnt_r;
    logic        owner_r;
    logic [3:0]  cnt_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        accept_s;
    logic        rsp_ack_s;

    logic [3:0]  req_opcode_s;
    logic [31:0] req_a_s;
    logic [31:0] req_b_s;
    logic [31:0] req_imm_s;
    logic        req_src_sel_s;
    logic [4:0]  req_shamt_s;

    // Extra EXEC cycles to spend on an opcode after the first one.
    function automatic logic [3:0] exec_cnt_load(input logic [3:0] op);
        logic [3:0] v;
        if (op == OP_MUL) begin
            v = MUL_CNT_INIT;
        end else begin
            v = 4'd0;
        end
        return v;
    endfunction

    // Round-robin grant, only meaningful in IDLE; a tie goes to the requester that was not served last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (r0_valid && r1_valid) begin
                if (last_gnt_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (r0_valid) begin
                gnt0_s = 1'b1;
            end else if (r1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // A grant implies the matching valid, so any grant is an accept.
    assign accept_s = gnt0_s | gnt1_s;

    // Ready is forced low while reset is asserted so every output reads 0 in reset.
    assign r0_ready = gnt0_s & rst_n;
    assign r1_ready = gnt1_s & rst_n;

    // Response handshake of whichever requester owns the in-flight op.
    assign rsp_ack_s = owner_r ? r1_rsp_ready : r0_rsp_ready;

    // Select the granted requester's fields for capture.
    always_comb begin
        req_opcode_s  = r0_opcode;
        req_a_s       = r0_a;
        req_b_s       = r0_b;
        req_imm_s     = r0_imm;
        req_src_sel_s = r0_src_sel;
        req_shamt_s   = r0_shamt;
        if (gnt1_s) begin
            req_opcode_s  = r1_opcode;
            req_a_s       = r1_a;
            req_b_s       = r1_b;
            req_imm_s     = r1_imm;
            req_src_sel_s = r1_src_sel;
            req_shamt_s   = r1_shamt;
        end else begin
            req_opcode_s  = r0_opcode;
            req_a_s       = r0_a;
            req_b_s       = r0_b;
            req_imm_s     = r0_imm;
            req_src_sel_s = r0_src_sel;
            req_shamt_s   = r0_shamt;
        end
    end

    // Main sequencer: accept, hold operands through EXEC, capture and hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            last_gnt_r    <= 1'b1;
            owner_r       <= 1'b0;
            cnt_r         <= 4'd0;
            busy          <= 1'b0;
            alu_enable    <= 1'b0;
            alu_opcode    <= 4'd0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_imm       <= 32'd0;
            alu_shift_amt <= 32'd0;
            alu_src_sel   <= 1'b0;
            rsp_data      <= 64'd0;
            rsp_z         <= 1'b0;
            rsp_c         <= 1'b0;
            r0_rsp_valid  <= 1'b0;
            r1_rsp_valid  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_opcode    <= req_opcode_s;
                        alu_a         <= req_a_s;
                        alu_b         <= req_b_s;
                        alu_imm       <= req_imm_s;
                        alu_src_sel   <= req_src_sel_s;
                        alu_shift_amt <= {27'd0, req_shamt_s};
                        owner_r       <= gnt1_s;
                        last_gnt_r    <= gnt1_s;
                        cnt_r         <= exec_cnt_load(req_opcode_s);
                        busy          <= 1'b1;
                        alu_enable    <= 1'b1;
                        state_r       <= ST_EXEC;
                    end else begin
                        busy          <= 1'b0;
                        alu_enable    <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_data     <= alu_data;
                        rsp_z        <= alu_z;
                        rsp_c        <= alu_c;
                        alu_enable   <= 1'b0;
                        r0_rsp_valid <= ~owner_r;
                        r1_rsp_valid <= owner_r;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Returning to IDLE here means no accept can share the handshake edge.
                    if (rsp_ack_s) begin
                        r0_rsp_valid <= 1'b0;
                        r1_rsp_valid <= 1'b0;
                        busy         <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r      <= ST_RESP;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    alu_enable   <= 1'b0;
                    r0_rsp_valid <= 1'b0;
                    r1_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    localparam int unsigned MUL_LAT = 2;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd12;
    localparam logic [3:0] OP_SHR = 4'd13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_valid, r0_ready, r0_src_sel, r0_rsp_valid, r0_rsp_ready;
    logic        r1_valid, r1_ready, r1_src_sel, r1_rsp_valid, r1_rsp_ready;
    logic [3:0]  r0_opcode, r1_opcode;
    logic [31:0] r0_a, r0_b, r0_imm, r1_a, r1_b, r1_imm;
    logic [4:0]  r0_shamt, r1_shamt;
    logic [63:0] rsp_data;
    logic        rsp_z, rsp_c, busy, alu_enable, alu_src_sel;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_imm, alu_shift_amt;
    logic [63:0] alu_data;
    logic        alu_z, alu_c;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode),
        .r0_a(r0_a), .r0_b(r0_b), .r0_imm(r0_imm), .r0_src_sel(r0_src_sel),
        .r0_shamt(r0_shamt), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode),
        .r1_a(r1_a), .r1_b(r1_b), .r1_imm(r1_imm), .r1_src_sel(r1_src_sel),
        .r1_shamt(r1_shamt), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_c(rsp_c), .busy(busy),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a),
        .alu_b(alu_b), .alu_imm(alu_imm), .alu_shift_amt(alu_shift_amt),
        .alu_src_sel(alu_src_sel), .alu_data(alu_data), .alu_z(alu_z), .alu_c(alu_c)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {z, c, data[63:0]}.
    function automatic logic [65:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm,
                                            input logic sel, input logic [31:0] sh);
        logic [31:0] o2;
        logic [63:0] d;
        logic        c;
        o2 = sel ? imm : b;
        c  = 1'b0;
        case (op)
            4'd0:  begin d = {32'd0, a} + {32'd0, o2}; c = d[32]; end
            4'd1:  begin d = {32'd0, a} - {32'd0, o2}; c = (a >= o2); end
            4'd2:  d = {32'd0, a} * {32'd0, o2};
            4'd3:  d = {32'd0, a & o2};
            4'd4:  d = {32'd0, a | o2};
            4'd5:  d = {32'd0, a ^ o2};
            4'd12: d = {32'd0, a} << sh[4:0];
            4'd13: d = {32'd0, a >> sh[4:0]};
            4'd14: d = 64'd0;
            4'd15: d = 64'd0;
            default: d = {32'd0, a};
        endcase
        return {(d == 64'd0), c, d};
    endfunction

    // The shared ALU itself, driven from the controller's registered operands.
    always_comb {alu_z, alu_c, alu_data} = alu_ref(alu_opcode, alu_a, alu_b, alu_imm, alu_src_sel, alu_shift_amt);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired t=%0t", name, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        else if (v0) return 0;
        else if (v1) return 1;
        else return -1;
    endfunction

    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_own  = 1'b0;
    int          cyc    = 0;
    int          t_acc  = 0;
    int          m_len  = 1;
    logic [3:0]  m_op   = 4'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_imm = 32'd0;
    logic        m_sel = 1'b0;
    logic [4:0]  m_sh = 5'd0;
    int          m_g;
    bit          m_rsp;

    always_comb m_g = pick(r0_valid, r1_valid, m_last);
    // The response phase starts once the op has spent its execute cycles.
    always_comb m_rsp = m_busy && ((cyc - t_acc) >= m_len);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_last <= 1'b1;
            cyc    <= 0;
            t_acc  <= 0;
        end else begin
            if (m_busy) begin
                if (m_rsp && (m_own ? r1_rsp_ready : r0_rsp_ready)) m_busy <= 1'b0;
            end else if (m_g >= 0) begin
                m_busy <= 1'b1;
                m_own  <= (m_g == 1);
                m_last <= (m_g == 1);
                t_acc  <= cyc + 1;
                if (m_g == 1) begin
                    m_op <= r1_opcode; m_a <= r1_a; m_b <= r1_b; m_imm <= r1_imm;
                    m_sel <= r1_src_sel; m_sh <= r1_shamt;
                    m_len <= (r1_opcode == OP_MUL) ? int'(MUL_LAT) : 1;
                end else begin
                    m_op <= r0_opcode; m_a <= r0_a; m_b <= r0_b; m_imm <= r0_imm;
                    m_sel <= r0_src_sel; m_sh <= r0_shamt;
                    m_len <= (r0_opcode == OP_MUL) ? int'(MUL_LAT) : 1;
                end
            end
            cyc <= cyc + 1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : cmp_blk
        logic [65:0] e;
        if (rst_n) begin
            chk("r0_ready", r0_ready, !m_busy && m_g == 0);
            chk("r1_ready", r1_ready, !m_busy && m_g == 1);
            chk("busy", busy, m_busy);
            chk("alu_enable", alu_enable, m_busy && !m_rsp);
            chk("r0_rsp_valid", r0_rsp_valid, m_rsp && !m_own);
            chk("r1_rsp_valid", r1_rsp_valid, m_rsp && m_own);
            if (m_rsp) begin
                e = alu_ref(m_op, m_a, m_b, m_imm, m_sel, {27'd0, m_sh});
                chk("rsp_data", rsp_data, e[63:0]);
                chk("rsp_zc", {rsp_z, rsp_c}, e[65:64]);
            end
            if (m_busy) begin
                chk("alu_ab", {alu_a, alu_b}, {m_a, m_b});
                chk("alu_imm_sh", {alu_imm, alu_shift_amt}, {m_imm, 27'd0, m_sh});
                chk("alu_op_sel", {alu_opcode, alu_src_sel}, {m_op, m_sel});
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic sel, input logic [4:0] sh);
        if (n == 0) begin
            r0_opcode = op; r0_a = a; r0_b = b; r0_imm = imm; r0_src_sel = sel; r0_shamt = sh; r0_valid = 1'b1;
        end else begin
            r1_opcode = op; r1_a = a; r1_b = b; r1_imm = imm; r1_src_sel = sel; r1_shamt = sh; r1_valid = 1'b1;
        end
    endtask

    // Raise a request and return #1 after its accept edge.
    task automatic send(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic sel, input logic [4:0] sh);
        bit ok;
        ok = 1'b0;
        set_req(n, op, a, b, imm, sel, sh);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((n == 0) ? r0_ready : r1_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("send_ready");
        @(posedge clk); #1;
        if (n == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    endtask

    // Count edges (accept edge = 1) until rsp_valid, and cycles with alu_enable.
    task automatic wait_rsp(input int n, output int edges, output int en);
        bit ok;
        ok = 1'b0; edges = 1; en = 0;
        for (int i = 0; i < 40; i++) begin
            if (alu_enable) en++;
            if ((n == 0) ? r0_rsp_valid : r1_rsp_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            edges++;
        end
        if (!ok) timeout("wait_rsp");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, busy, alu_enable,
                            alu_src_sel, rsp_z, rsp_c, alu_opcode}, 64'd0);
        chk({tag, "_data"}, rsp_data, 64'd0);
        chk({tag, "_ab"}, {alu_a, alu_b}, 64'd0);
        chk({tag, "_imm_sh"}, {alu_imm, alu_shift_amt}, 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int e, en;
        int gseq [12];
        int expg;
        r0_valid = 1'b0; r1_valid = 1'b0;
        set_req(0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        set_req(1, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with carry out of bit 31
        send(0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0);
        chk("add_busy_t0", busy, 1'b1);
        wait_rsp(0, e, en);
        chk("add_edges", e, 2);
        chk("add_data", rsp_data, 64'h0000_0001_0000_0000);
        chk("add_zc", {rsp_z, rsp_c}, 2'b01);
        chk("add_busy_t1", busy, 1'b1);
        @(posedge clk); #1;
        chk("add_busy_off", busy, 1'b0);

        // MUL from r1 using the immediate
        send(1, OP_MUL, 32'h0001_0000, 32'd0, 32'h0001_0000, 1'b1, 5'd0);
        wait_rsp(1, e, en);
        chk("mul_edges", e, 3);
        chk("mul_en_cycles", en, 2);
        chk("mul_data", rsp_data, 64'h0000_0001_0000_0000);
        chk("mul_r0_rsp_valid", r0_rsp_valid, 1'b0);
        wait_idle();

        // SUB with a 4-cycle response stall while r1 waits
        r0_rsp_ready = 1'b0;
        send(0, OP_SUB, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0);
        wait_rsp(0, e, en);
        set_req(1, OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sub_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("sub_c", rsp_c, 1'b0);
            chk("sub_readys", {r0_ready, r1_ready}, 2'b00);
            chk("sub_rsp_valid", r0_rsp_valid, 1'b1);
        end
        r0_rsp_ready = 1'b1;
        send(1, OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0);
        wait_rsp(1, e, en);
        chk("stall_next_data", rsp_data, 64'd7);
        wait_idle();

        // Request fields changing after accept must not reach the ALU
        send(0, OP_SHL, 32'd1, 32'd0, 32'd0, 1'b0, 5'd31);
        r0_a = 32'h1234_5678; r0_opcode = OP_SHR;
        wait_rsp(0, e, en);
        chk("shl_data", rsp_data, 64'h0000_0000_8000_0000);
        chk("shl_alu_a", alu_a, 32'd1);
        wait_idle();

        // Unused opcode: ALU returns zero
        send(1, 4'd14, 32'hABCD, 32'd1, 32'd0, 1'b0, 5'd3);
        wait_rsp(1, e, en);
        chk("op14_data", rsp_data, 64'd0);
        chk("op14_z", rsp_z, 1'b1);
        wait_idle();

        // Reset in the second cycle of a MUL
        send(0, OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0);
        @(posedge clk); #2;
        r0_valid = 1'b1; r1_valid = 1'b1;
        rst_n = 1'b0;
        #1 chk_zero("rst_exec");
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lost_op_quiet", {r0_rsp_valid, r1_rsp_valid, busy}, 3'b000);
        end

        // Round-robin with both requesters held valid
        @(posedge clk); #1;
        set_req(0, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0);
        set_req(1, OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (r0_ready) gseq[k] = 0;
            else if (r1_ready) gseq[k] = 1;
            else gseq[k] = -1;
        end
        for (int k = 0; k < 12; k++) begin
            expg = ((k % 3) == 0) ? ((k / 3) % 2) : -1;
            chk($sformatf("rr_grant%0d", k), gseq[k], expg);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        wait_idle();

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            r0_valid = 1'($urandom_range(0, 1));
            r1_valid = 1'($urandom_range(0, 1));
            r0_opcode = ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
            r1_opcode = ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
            r0_a = $urandom; r0_b = $urandom; r0_imm = $urandom;
            r1_a = $urandom; r1_b = $urandom; r1_imm = $urandom;
            r0_src_sel = 1'($urandom_range(0, 1)); r1_src_sel = 1'($urandom_range(0, 1));
            r0_shamt = 5'($urandom_range(0, 31)); r1_shamt = 5'($urandom_range(0, 31));
            r0_rsp_ready = ($urandom_range(0, 3) != 0);
            r1_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
